riscv_mem_responder: RTL
========================

// Module: riscv_mem_responder
// PURPOSE
//  Memory-side responder for the core's instruction/data bus.
//  Accepts one request at a time (read or byte-masked write) on a valid/ready channel.
//  Backs it with an internal word array mapped at BASE_ADDR.
//  Returns a response (read data + error flag) on a second valid/ready channel after a fixed latency.
//  Sits between the riscv core's fetch/LSU request port and on-chip RAM; also used as the bench memory model.
// PARAMETERS
//  XLEN         64            data/address width; legal values 32 or 64 only, anything else -> $fatal at elaboration
//  BASE_ADDR    32'h8000_0000 byte address of word 0; zero-extended to XLEN; matches core reset vector
//  DEPTH_WORDS  1024          number of XLEN-wide words; power of 2, >= 2
//  LATENCY      1             cycles from request accept to resp_valid; legal range 1..15
// PORTS
//  clk        in   1        clock, all state on rising edge
//  reset      in   1        asynchronous, active-high reset
//  req_valid  in   1        request present
//  req_ready  out  1        responder can accept request
//  req_addr   in   XLEN     byte address
//  req_we     in   1        1 = write, 0 = read
//  req_wdata  in   XLEN     write data
//  req_wstrb  in   XLEN/8   byte enables for writes; bit i -> byte i; ignored on reads
//  resp_valid out  1        response present
//  resp_ready in   1        consumer accepts response
//  resp_rdata out  XLEN     read data; 0 for writes and errors
//  resp_err   out  1        access fault (misaligned or out of range)
// BEHAVIOUR
//  Reset (async assert):
//   - FSM -> IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
//   - Memory array is NOT reset; contents are retained.
//  FSM: IDLE -> WAIT -> RESP -> IDLE. Exactly one transaction is outstanding.
//   - IDLE: req_ready=1. Accept occurs when req_valid & req_ready at a rising edge.
//     On accept: latch decode result and read data; commit write; counter=LATENCY-1.
//     Next state is RESP if LATENCY==1, else WAIT.
//   - WAIT: req_ready=0; counter decrements each cycle; go to RESP when counter==1.
//   - RESP: resp_valid=1; rdata/err held stable until resp_ready. On the handshake edge -> IDLE.
//     No bypass: earliest next accept is the cycle after the response handshake,
//     so back-to-back throughput is one transaction per LATENCY+1 cycles.
//  Latency: resp_valid rises exactly LATENCY cycles after the accept edge.
//  Decode (offset = req_addr - BASE_ADDR, computed in XLEN bits):
//   - Misaligned fault: req_addr[log2(XLEN/8)-1:0] != 0.
//   - Out-of-range fault: req_addr < BASE_ADDR, or offset >= DEPTH_WORDS*XLEN/8.
//   - Word index = offset >> log2(XLEN/8).
//  Faults: resp_err=1, resp_rdata=0, no array access; the write is suppressed.
//  Read: resp_rdata = array[index], sampled at the accept edge.
//  Write: for every i with wstrb[i]=1, byte i of array[index] is updated at the accept edge.
//   - resp_rdata=0, resp_err=0.
//   - wstrb == 0 is a legal no-op write with an OK response.
//  Ordering: a read following a write to the same word returns the new data.
//  req_* inputs are don't-care outside the IDLE accept cycle.
//  resp_ready may be held high permanently, or may stall indefinitely in RESP.
//  Reset mid-transaction:
//   - An in-flight response is dropped.
//   - A write already committed at its accept edge stays committed.
//   - Outputs return to reset values immediately (async).
// TESTING
//  1. Reset: assert reset mid-WAIT (LATENCY=3) -> resp_valid=0 and req_ready=1 immediately; no response is ever emitted.
//  2. XLEN=64, LATENCY=1: write 0x1122_3344_5566_7788 @0x8000_0010 with wstrb=0xFF, then read it back
//     -> each resp_valid exactly 1 cycle after accept; read resp_rdata=0x1122_3344_5566_7788, resp_err=0.
//  3. Partial write wstrb=0x0F, wdata=0xAAAA_AAAA_BBBB_BBBB to the same word, then read
//     -> resp_rdata=0x1122_3344_BBBB_BBBB.
//  4. Faults:
//     - Read @0x8000_0004 (misaligned) -> resp_err=1, rdata=0.
//     - Write @0x7FFF_FFF8 (below base) -> resp_err=1, memory unchanged.
//     - Read @0x8000_2000 (DEPTH=1024, first out-of-range word) -> resp_err=1.
//  5. Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata/err stable, req_ready=0;
//     release -> IDLE next cycle.
//  6. LATENCY=4 streaming with req_valid held high -> accepts spaced exactly 5 cycles apart, responses in order.

Source files
------------

// File: rtl/riscv_mem_responder.sv
// Single-outstanding memory responder: valid/ready request channel, internal word array
// mapped at BASE_ADDR, and a response channel that presents data a fixed LATENCY after accept.
module riscv_mem_responder #(
  parameter int unsigned XLEN        = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int unsigned     NBYTES   = XLEN / 8;
  localparam int unsigned     OFF_BITS = $clog2(NBYTES);
  localparam int unsigned     IDX_BITS = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] BASE_X   = XLEN'(BASE_ADDR);
  localparam logic [XLEN-1:0] SPAN_X   = XLEN'(DEPTH_WORDS * NBYTES);
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);
  localparam bit              LAT_ONE  = (LATENCY == 1);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "riscv_mem_responder: XLEN must be 32 or 64");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "riscv_mem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $fatal(1, "riscv_mem_responder: DEPTH_WORDS must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [XLEN-1:0]       mem_q [DEPTH_WORDS];

  logic [XLEN-1:0]       offset_s;
  logic [IDX_BITS-1:0]   idx_s;
  logic                  misalign_s;
  logic                  range_err_s;
  logic                  fault_s;
  logic                  accept_s;
  logic                  wr_en_s;

  // Offset is taken modulo 2^XLEN, so addresses below base wrap high and fail the span test too.
  always_comb begin
    offset_s    = req_addr - BASE_X;
    idx_s       = offset_s[OFF_BITS +: IDX_BITS];
    misalign_s  = |req_addr[OFF_BITS-1:0];
    range_err_s = (req_addr < BASE_X) || (offset_s >= SPAN_X);
    fault_s     = misalign_s || range_err_s;
    accept_s    = req_valid && req_ready;
    wr_en_s     = accept_s && req_we && !fault_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= {XLEN{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cnt_d   = CNT_INIT;
          state_d = LAT_ONE ? S_RESP : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response payload is captured at accept and held until the response handshake clears it.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept_s) begin
      err_d   = fault_s;
      rdata_d = (fault_s || req_we) ? {XLEN{1'b0}} : mem_q[idx_s];
    end else if (state_q == S_RESP && resp_ready) begin
      rdata_d = {XLEN{1'b0}};
      err_d   = 1'b0;
    end else begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE:  req_ready  = 1'b1;
      S_WAIT:  req_ready  = 1'b0;
      S_RESP:  resp_valid = 1'b1;
      default: begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
      end
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (req_wstrb[i]) begin
          mem_q[idx_s][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
